// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low patterns for 0-F, segment bit
// positions and the pattern-to-hex decode used by both driver and reader sides.
package seg7_pkg;

    localparam int unsigned SEG_A  = 7;
    localparam int unsigned SEG_B  = 6;
    localparam int unsigned SEG_C  = 5;
    localparam int unsigned SEG_D  = 4;
    localparam int unsigned SEG_E  = 3;
    localparam int unsigned SEG_F  = 2;
    localparam int unsigned SEG_G  = 1;
    localparam int unsigned SEG_DP = 0;

    // Full active-low byte per hex digit, decimal point off.
    localparam logic [7:0] SEG7_PAT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef struct packed {
        logic       legal;
        logic [3:0] nibble;
    } seg7_hex_t;

    function automatic seg7_hex_t seg7_to_hex(input logic [6:0] pat);
        seg7_hex_t res;
        res.legal  = 1'b0;
        res.nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG7_PAT[i][SEG_A:SEG_G]) begin
                res.legal  = 1'b1;
                res.nibble = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low a..g pattern to a hex nibble plus a
// legal flag; unknown patterns (including blank) report legal = 0.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    seg7_hex_t w_hex;

    assign w_hex    = seg7_to_hex(i_pat);
    assign o_legal  = w_hex.legal;
    assign o_nibble = w_hex.nibble;

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment display: synchronizes the pins,
// waits for a stable digit slot, decodes it and holds one nibble per digit.
// Define SEG7_SCAN_READER_DP_EN to capture decimal points; otherwise dp is 0
// and the dp pin is ignored by the stability check.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     err,
    output logic                  upd,
    output logic                  frame
);

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
`ifdef SEG7_SCAN_READER_DP_EN
    localparam logic [7:0] CMP_MASK = 8'hFF;
`else
    localparam logic [7:0] CMP_MASK = 8'hFE;
`endif

    logic [7:0]          r_seg_s1, r_seg_s2;
    logic [DIGITS-1:0]   r_dig_s1, r_dig_s2;
    logic [7:0]          r_cnt;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_err;
    logic                r_upd, r_frame;

    logic                w_same, w_onehot, w_capture, w_seen_full, w_legal;
    logic [DIGITS-1:0]   w_sel, w_seen_or;
    logic [7:0]          w_cnt_nxt;
    logic [3:0]          w_nibble;

    // The second synchronizer flop doubles as the held sample, so the first
    // comparison happens as soon as a new value leaves the first flop.
    assign w_same    = (((r_seg_s1 ^ r_seg_s2) & CMP_MASK) == 8'h00) &&
                       (r_dig_s1 == r_dig_s2);
    assign w_sel     = ~r_dig_s2;
    assign w_onehot  = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    assign w_capture = w_same && (r_cnt == CNT_LAST) && w_onehot;
    assign w_cnt_nxt = !w_same ? 8'h00 :
                       (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 8'h01;

    assign w_seen_or   = r_seen | w_sel;
    assign w_seen_full = &w_seen_or;

    seg7_decode u_decode (
        .i_pat    (r_seg_s2[SEG_A:SEG_G]),
        .o_legal  (w_legal),
        .o_nibble (w_nibble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
            r_dig_s1 <= '1;
            r_dig_s2 <= '1;
            r_cnt    <= '0;
        end else begin
            r_seg_s1 <= seg_n;
            r_seg_s2 <= r_seg_s1;
            r_dig_s1 <= dig_n;
            r_dig_s2 <= r_dig_s1;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_err   <= '0;
            r_seen  <= '0;
            r_upd   <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_upd   <= w_capture;
            r_frame <= w_capture && w_seen_full;
            if (w_capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (w_sel[i] && w_legal) begin
                        r_value[4*i +: 4] <= w_nibble;
                    end
                end
                r_err  <= (r_err & ~w_sel) | (w_sel & {DIGITS{~w_legal}});
                r_seen <= w_seen_full ? '0 : w_seen_or;
            end
        end
    end

`ifdef SEG7_SCAN_READER_DP_EN
    logic [DIGITS-1:0] r_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp <= '0;
        end else if (w_capture) begin
            r_dp <= (r_dp & ~w_sel) | (w_sel & {DIGITS{~r_seg_s2[SEG_DP]}});
        end
    end

    assign dp = r_dp;
`else
    assign dp = '0;
`endif

    assign value = r_value;
    assign err   = r_err;
    assign upd   = r_upd;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: drives held input segments and predicts every
// capture from the run length of identical samples.
module tb_seg7_scan_reader;

    localparam int DIGITS = 4;
    localparam int S      = 4;
`ifdef SEG7_SCAN_READER_DP_EN
    localparam logic [7:0] KMASK = 8'hFF;
    localparam bit         DP_ON = 1'b1;
`else
    localparam logic [7:0] KMASK = 8'hFE;
    localparam bit         DP_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [7:0]            seg_n = 8'hFF;
    logic [DIGITS-1:0]     dig_n = '1;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp, err;
    logic                  upd, frame;

    seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
        .value(value), .dp(dp), .err(err), .upd(upd), .frame(frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int act_upd[$], act_frm[$], exp_upd[$], exp_frm[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (upd === 1'b1)   act_upd.push_back(edge_cnt);
        if (frame === 1'b1) act_frm.push_back(edge_cnt);
    end

    logic [7:0] PAT [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Reference state: a run is a stretch of identical (masked) samples.
    logic [8+DIGITS-1:0] run_key;
    int                  run_start, run_len;
    bit                  run_done;
    logic [7:0]          run_seg;
    logic [DIGITS-1:0]   run_dig;
    logic [3:0]          m_val [DIGITS];
    bit                  m_err [DIGITS];
    bit                  m_dp  [DIGITS];
    logic [DIGITS-1:0]   m_seen;

    task automatic model_reset();
        run_key  = '1;
        run_done = 1'b1;
        run_len  = 0;
        m_seen   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            m_val[i] = 4'h0; m_err[i] = 1'b0; m_dp[i] = 1'b0;
        end
        exp_upd.delete(); exp_frm.delete(); act_upd.delete(); act_frm.delete();
    endtask

    task automatic model_capture(input int at_edge);
        int  idx;
        bit  legal;
        idx = -1;
        if ($countones(~run_dig) != 1) return;
        for (int i = 0; i < DIGITS; i++) if (!run_dig[i]) idx = i;
        exp_upd.push_back(at_edge);
        legal = 1'b0;
        for (int p = 0; p < 16; p++) begin
            if (run_seg[7:1] == PAT[p][7:1]) begin
                legal = 1'b1;
                m_val[idx] = 4'(p);
            end
        end
        m_err[idx] = !legal;
        if (DP_ON) m_dp[idx] = !run_seg[0];
        m_seen[idx] = 1'b1;
        if (m_seen == '1) begin
            exp_frm.push_back(at_edge);
            m_seen = '0;
        end
    endtask

    // Called at a falling edge; holds the inputs for len rising edges.
    task automatic apply(input logic [7:0] s, input logic [DIGITS-1:0] d, input int len);
        logic [8+DIGITS-1:0] key;
        seg_n = s;
        dig_n = d;
        key = {s & KMASK, d};
        if (key != run_key) begin
            run_key = key; run_start = edge_cnt + 1; run_len = 0;
            run_done = 1'b0; run_seg = s; run_dig = d;
        end
        run_len += len;
        if (!run_done && run_len >= S + 1) begin
            run_done = 1'b1;
            model_capture(run_start + S + 1);
        end
        repeat (len) @(negedge clk);
    endtask

    task automatic idle();
        apply(8'hFF, '1, S + 3);
        #1;
    endtask

    function automatic logic [4*DIGITS-1:0] m_value_vec();
        for (int i = 0; i < DIGITS; i++) m_value_vec[4*i +: 4] = m_val[i];
    endfunction

    function automatic logic [2*DIGITS-1:0] m_flag_vec();
        for (int i = 0; i < DIGITS; i++) begin
            m_flag_vec[i] = m_err[i];
            m_flag_vec[DIGITS + i] = m_dp[i];
        end
    endfunction

    function automatic bit queues_equal(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        int rel;
        @(negedge clk);
        seg_n = 8'($urandom); dig_n = DIGITS'($urandom);
        #1;
        n_cmp++;
        if ({value, dp, err, upd, frame} !== '0) begin
            n_bad++; $display("FAIL reset_outputs got %h want 0", {value, dp, err, upd, frame});
        end
        repeat (3) begin
            @(negedge clk);
            seg_n = 8'($urandom); dig_n = DIGITS'($urandom);
        end
        #1;
        n_cmp++;
        if ({value, dp, err, upd, frame} !== '0) begin
            n_bad++; $display("FAIL reset_hold got %h want 0", {value, dp, err, upd, frame});
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        rel = edge_cnt + 1;
        apply(8'h0D, 4'b0111, S + 4);
        idle();
        n_cmp++;
        if (act_upd.size() < 1 || act_upd[0] - rel + 1 != S + 2) begin
            n_bad++;
            $display("FAIL reset_first_upd got %0d upd, first at edge %0d want edge %0d",
                     act_upd.size(), act_upd.size() ? act_upd[0] - rel + 1 : -1, S + 2);
        end
        n_cmp++;
        if (!queues_equal(act_upd, exp_upd)) begin
            n_bad++; $display("FAIL reset_upd_times got %0d pulses want %0d", act_upd.size(), exp_upd.size());
        end
    endtask

    task automatic test_single_digit();
        int st;
        act_upd.delete(); exp_upd.delete();
        st = edge_cnt + 1;
        apply(8'h25, 4'b1110, 10);
        idle();
        n_cmp++;
        if (act_upd.size() != 1 || act_upd[0] - st + 1 != 6) begin
            n_bad++; $display("FAIL single_upd got %0d pulses (first edge %0d) want 1 at edge 6",
                              act_upd.size(), act_upd.size() ? act_upd[0] - st + 1 : -1);
        end
        n_cmp++;
        if ({value[3:0], err[0], dp[0]} !== {4'h2, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL single_value got %h/%b/%b want 2/0/0", value[3:0], err[0], dp[0]);
        end
    endtask

    task automatic test_glitch();
        act_upd.delete(); exp_upd.delete();
        apply(8'h03, 4'b1101, 8);
        apply(8'h99, 4'b1101, 3);
        apply(8'h03, 4'b1101, 3);
        idle();
        n_cmp++;
        if (value[7:4] !== 4'h0 || act_upd.size() != 1) begin
            n_bad++; $display("FAIL glitch got value %h with %0d upd want 0 with 1", value[7:4], act_upd.size());
        end
        n_cmp++;
        if (!queues_equal(act_upd, exp_upd)) begin
            n_bad++; $display("FAIL glitch_upd_times got %0d pulses want %0d", act_upd.size(), exp_upd.size());
        end
    endtask

    task automatic test_illegal_multi();
        apply(8'h41, 4'b1011, 8);
        apply(8'hFF, 4'b1011, 8);
        idle();
        n_cmp++;
        if (err[2] !== 1'b1 || value[11:8] !== 4'h6) begin
            n_bad++; $display("FAIL illegal got err %b value %h want 1 6", err[2], value[11:8]);
        end
        act_upd.delete(); exp_upd.delete();
        apply(8'h03, 4'b1100, 12);
        idle();
        n_cmp++;
        if (act_upd.size() != 0) begin
            n_bad++; $display("FAIL multi_select got %0d upd want 0", act_upd.size());
        end
    endtask

    task automatic scan4(input int dwell);
        apply(8'h9F, 4'b1110, dwell);
        apply(8'h0D, 4'b1101, dwell);
        apply(8'h61, 4'b1011, dwell);
        apply(8'h70, 4'b0111, dwell);
        idle();
    endtask

    task automatic test_full_scan();
        act_upd.delete(); exp_upd.delete(); act_frm.delete(); exp_frm.delete();
        scan4(8);
        n_cmp++;
        if (value !== 16'hFE31 || dp !== (DP_ON ? 4'b1000 : 4'b0000)) begin
            n_bad++; $display("FAIL full_scan got value %h dp %b want FE31 %b", value, dp, DP_ON ? 4'b1000 : 4'b0000);
        end
        n_cmp++;
        if (act_frm.size() != 1 || act_upd.size() != 4 || act_frm[0] != act_upd[3]) begin
            n_bad++; $display("FAIL full_scan_frame got %0d frames %0d upd want 1 on 4th upd", act_frm.size(), act_upd.size());
        end
        n_cmp++;
        if (!queues_equal(act_frm, exp_frm) || !queues_equal(act_upd, exp_upd)) begin
            n_bad++; $display("FAIL full_scan_model got %0d/%0d want %0d/%0d",
                              act_upd.size(), act_frm.size(), exp_upd.size(), exp_frm.size());
        end
    endtask

    task automatic test_reset_midscan();
        act_upd.delete(); exp_upd.delete();
        apply(8'h9F, 4'b1110, 8);
        apply(8'h0D, 4'b1101, 8);
        apply(8'h61, 4'b1011, 3);
        n_cmp++;
        if (!queues_equal(act_upd, exp_upd)) begin
            n_bad++; $display("FAIL midscan_pre got %0d upd want %0d", act_upd.size(), exp_upd.size());
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({value, dp, err, upd, frame} !== '0) begin
            n_bad++; $display("FAIL midscan_clear got %h want 0", {value, dp, err, upd, frame});
        end
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        scan4(8);
        n_cmp++;
        if (act_frm.size() != 1 || act_upd.size() != 4 || act_frm[0] != act_upd[3]) begin
            n_bad++; $display("FAIL midscan_frame got %0d frames %0d upd want 1 on 4th upd", act_frm.size(), act_upd.size());
        end
        n_cmp++;
        if (value !== m_value_vec() || {dp, err} !== m_flag_vec()) begin
            n_bad++; $display("FAIL midscan_state got %h %b want %h %b", value, {dp, err}, m_value_vec(), m_flag_vec());
        end
    endtask

    task automatic test_dp_flicker();
        act_upd.delete(); exp_upd.delete();
        for (int k = 0; k < 5; k++) apply((k % 2) ? 8'h24 : 8'h25, 4'b1110, 2);
        idle();
        n_cmp++;
        if (!queues_equal(act_upd, exp_upd) || act_upd.size() != (DP_ON ? 0 : 1)) begin
            n_bad++; $display("FAIL dp_flicker got %0d upd want %0d", act_upd.size(), exp_upd.size());
        end
    endtask

    task automatic test_random();
        logic [7:0]        s;
        logic [DIGITS-1:0] d;
        act_upd.delete(); exp_upd.delete(); act_frm.delete(); exp_frm.delete();
        for (int k = 0; k < 80; k++) begin
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (PAT[$urandom_range(0, 15)] ^ 8'($urandom_range(0, 1)));
            d = ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : ~(DIGITS'(1) << $urandom_range(0, DIGITS - 1));
            apply(s, d, $urandom_range(1, 10));
        end
        idle();
        n_cmp++;
        if (!queues_equal(act_upd, exp_upd) || !queues_equal(act_frm, exp_frm)) begin
            n_bad++; $display("FAIL random_pulses got %0d/%0d want %0d/%0d",
                              act_upd.size(), act_frm.size(), exp_upd.size(), exp_frm.size());
        end
        n_cmp++;
        if (value !== m_value_vec() || {dp, err} !== m_flag_vec()) begin
            n_bad++; $display("FAIL random_state got %h %b want %h %b", value, {dp, err}, m_value_vec(), m_flag_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_glitch();
        test_illegal_multi();
        test_full_scan();
        test_reset_midscan();
        test_dp_flicker();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
